// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch front end.
// Holds the FIFO entry layout, request FSM states and the RVC length check.
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef struct packed {
    logic               err;
    logic [INSTR_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE,
    REQ
  } req_state_e;

  function automatic logic is_compressed(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Flop-based shift queue of fetched words with error tags.
// Exposes the two oldest entries so the aligner can straddle word boundaries.
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear_i,
  input  logic          push_i,
  input  fifo_entry_t   wdata_i,
  input  logic          pop_i,
  output fifo_entry_t   head_o,
  output fifo_entry_t   head1_o,
  output logic [CW-1:0] count_o
);

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wptr;
  logic          do_pop;

  always_comb begin
    mem_d  = mem_q;
    do_pop = pop_i && (count_q != '0);
    wptr   = count_q - CW'(do_pop);
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    // Write lands after the shift so push+pop at full reuses the freed slot
    if (push_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wptr == CW'(i)) mem_d[i] = wdata_i;
      end
    end
    count_d = wptr + CW'(push_i);
    if (clear_i) count_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head_o  = mem_q[0];
  assign head1_o = mem_q[1];
  assign count_o = count_q;

  overflow_a: assert property (@(posedge clk) disable iff (!rstn)
    !(push_i && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Fetch front end: credit-limited bus requests, response squash on redirect,
// word FIFO and 16/32-bit realignment towards decode.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int          DEPTH           = 3,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  output logic        out_err_o
);

  localparam int CW = $clog2(DEPTH + 1);

  req_state_e    state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] fcount, fcount_d;
  logic [CW:0]   inflight_d;

  fifo_entry_t head, head1, rsp, w1;
  logic        push, pop, fire, gnt_acc;
  logic        c_lo, c_hi, have0, have1;
  logic        valid, comp, err, pop_w0;
  logic [31:0] instr;

  assign rsp     = '{err: instr_err_i, data: instr_rdata_i};
  assign gnt_acc = instr_req_o && instr_gnt_i;
  assign push    = instr_rvalid_i && (disc_q == '0) && !redirect_i;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (redirect_i),
    .push_i  (push),
    .wdata_i (rsp),
    .pop_i   (pop),
    .head_o  (head),
    .head1_o (head1),
    .count_o (fcount)
  );

  always_comb begin
    c_lo   = is_compressed(head.data[1:0]);
    c_hi   = is_compressed(head.data[17:16]);
    have0  = fcount != '0;
    have1  = (fcount >= CW'(2)) || (fcount == CW'(1) && push);
    w1     = (fcount >= CW'(2)) ? head1 : rsp;
    valid  = 1'b0;
    comp   = 1'b0;
    err    = 1'b0;
    pop_w0 = 1'b0;
    instr  = head.data;
    unique case (1'b1)
      !out_pc_q[1]: begin
        comp   = c_lo;
        instr  = c_lo ? {16'h0, head.data[15:0]} : head.data;
        valid  = have0;
        err    = head.err;
        pop_w0 = !c_lo;
      end
      out_pc_q[1] && c_hi: begin
        comp   = 1'b1;
        instr  = {16'h0, head.data[31:16]};
        valid  = have0;
        err    = head.err;
        pop_w0 = 1'b1;
      end
      out_pc_q[1] && !c_hi: begin
        // An erroring first half need not wait for the second word
        instr  = {w1.data[15:0], head.data[31:16]};
        valid  = have0 && (have1 || head.err);
        err    = head.err || (have1 && w1.err);
        pop_w0 = 1'b1;
      end
      default: ;
    endcase
  end

  assign fire = valid && out_ready_i;
  assign pop  = fire && pop_w0 && !redirect_i;

  always_comb begin
    outst_d = outst_q + CW'(gnt_acc) - CW'(instr_rvalid_i);
    if (redirect_i) begin
      fcount_d     = '0;
      disc_d       = outst_q - CW'(instr_rvalid_i);
      fetch_addr_d = redirect_pc_i & 32'hFFFF_FFFC;
      out_pc_d     = redirect_pc_i & 32'hFFFF_FFFE;
    end else begin
      fcount_d     = fcount + CW'(push) - CW'(pop);
      disc_d       = disc_q;
      if (instr_rvalid_i && disc_q != '0) disc_d = disc_q - CW'(1);
      fetch_addr_d = gnt_acc ? fetch_addr_q + 32'd4 : fetch_addr_q;
      out_pc_d     = out_pc_q;
      if (fire) out_pc_d = out_pc_q + (comp ? 32'd2 : 32'd4);
    end
    inflight_d = {1'b0, outst_d} + {1'b0, fcount_d};
    state_d    = IDLE;
    if (inflight_d < (CW+1)'(DEPTH) && outst_d < CW'(MAX_OUTSTANDING)) begin
      state_d = REQ;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      fetch_addr_q <= PC_RESET & 32'hFFFF_FFFC;
      out_pc_q     <= PC_RESET & 32'hFFFF_FFFC;
      outst_q      <= '0;
      disc_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      out_pc_q     <= out_pc_d;
      outst_q      <= outst_d;
      disc_q       <= disc_d;
    end
  end

  assign instr_req_o      = (state_q == REQ) && !redirect_i;
  assign instr_addr_o     = fetch_addr_q;
  assign out_valid_o      = valid;
  assign out_instr_o      = instr;
  assign out_pc_o         = out_pc_q;
  assign out_compressed_o = comp;
  assign out_err_o        = valid && err;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: bus model with in-order responses
// and a scoreboard of expected instructions checked as decode accepts them.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] PC_RST = 32'h80;
  localparam int          DEPTH  = 3;
  localparam int          MAXO   = 2;

  logic        clk;
  logic        rstn;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_compressed_o;
  logic        out_err_o;

  instr_prefetch_buffer #(
    .PC_RESET        (PC_RST),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .instr_req_o      (instr_req_o),
    .instr_gnt_i      (instr_gnt_i),
    .instr_addr_o     (instr_addr_o),
    .instr_rvalid_i   (instr_rvalid_i),
    .instr_rdata_i    (instr_rdata_i),
    .instr_err_i      (instr_err_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_instr_o      (out_instr_o),
    .out_pc_o         (out_pc_o),
    .out_compressed_o (out_compressed_o),
    .out_err_o        (out_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pend[$];
  logic [31:0] mem_ovr [logic [31:0]];
  bit          err_map [logic [31:0]];
  int          fire_cyc[$];

  int          checks;
  int          failures;
  int          cyc;
  int          grants;
  int          budget;
  bit          rdy_en;
  bit          redir_req;
  logic [31:0] redir_pc;
  logic [31:0] snap_pc;
  logic [31:0] snap_instr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a << 8) | 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_i(input logic [31:0] pc, input logic [31:0] ins,
                          input logic comp, input logic err,
                          input logic chk_data);
    exp_t e;
    e.pc       = pc;
    e.instr    = ins;
    e.comp     = comp;
    e.err      = err;
    e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  task automatic step();
    logic [31:0] a;
    exp_t        e;
    @(negedge clk);
    if (pend.size() != 0 && budget != 0) begin
      a              = pend.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_rd(a);
      instr_err_i    = err_map.exists(a);
      if (budget > 0) budget--;
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
    end
    instr_gnt_i   = 1'b1;
    out_ready_i   = rdy_en && (sb.size() != 0);
    redirect_i    = redir_req;
    redirect_pc_i = redir_pc;
    redir_req     = 1'b0;
    #1;
    if (instr_req_o && instr_gnt_i) begin
      pend.push_back(instr_addr_o);
      grants++;
    end
    if (out_valid_o && out_ready_i) begin
      e = sb.pop_front();
      fire_cyc.push_back(cyc);
      chk($sformatf("pc_%h", e.pc), out_pc_o, e.pc);
      chk($sformatf("err_%h", e.pc), 32'(out_err_o), 32'(e.err));
      if (e.chk_data) begin
        chk($sformatf("instr_%h", e.pc), out_instr_o, e.instr);
        chk($sformatf("comp_%h", e.pc), 32'(out_compressed_o), 32'(e.comp));
      end
    end
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_left"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic quiesce();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((pend.size() != 0 || instr_req_o) && n < 100);
    chk("quiesce", 32'(pend.size() != 0 || instr_req_o), 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redir_req = 1'b1;
    redir_pc  = pc;
    step();
    chk("redir_noreq", 32'(instr_req_o), 32'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    grants         = 0;
    budget         = -1;
    rdy_en         = 1'b1;
    redir_req      = 1'b0;
    redir_pc       = '0;
    rstn           = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    redirect_i     = 1'b0;
    redirect_pc_i  = '0;
    out_ready_i    = 1'b0;

    #12;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_err", 32'(out_err_o), 32'd0);
    chk("rst_pc", out_pc_o, PC_RST);
    chk("rst_addr", instr_addr_o, PC_RST);
    @(negedge clk);
    rstn = 1'b1;

    // sequential 32-bit stream, one per cycle once primed
    for (int i = 0; i < 4; i++) begin
      expect_i(PC_RST + 32'(4 * i), mem_rd(PC_RST + 32'(4 * i)), 1'b0, 1'b0, 1'b1);
    end
    drain("seq");
    if (fire_cyc.size() >= 4) begin
      chk("seq_rate", 32'(fire_cyc[3] - fire_cyc[0]), 32'd3);
    end else begin
      chk("seq_fires", 32'(fire_cyc.size()), 32'd4);
    end

    // mixed compressed / 32-bit
    quiesce();
    mem_ovr[32'h0] = 32'h0001_0001;
    mem_ovr[32'h4] = 32'h4501_0513;
    do_redirect(32'h0);
    expect_i(32'h0, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    expect_i(32'h2, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    expect_i(32'h4, 32'h4501_0513, 1'b0, 1'b0, 1'b1);
    expect_i(32'h8, mem_rd(32'h8), 1'b0, 1'b0, 1'b1);
    drain("rvc");

    // unaligned 32-bit straddling two words
    quiesce();
    mem_ovr[32'h100] = 32'h0513_0001;
    mem_ovr[32'h104] = 32'h0000_0593;
    budget = 0;
    do_redirect(32'h102);
    expect_i(32'h102, 32'h0593_0513, 1'b0, 1'b0, 1'b1);
    expect_i(32'h106, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    expect_i(32'h108, mem_rd(32'h108), 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    chk("strad_cap_req", 32'(instr_req_o), 32'd0);
    budget = 1;
    step();
    step();
    chk("strad_wait1", 32'(out_valid_o), 32'd0);
    step();
    chk("strad_wait2", 32'(out_valid_o), 32'd0);
    budget = -1;
    drain("strad");

    // redirect squashes two in-flight responses
    quiesce();
    budget = 0;
    do_redirect(32'h300);
    step();
    step();
    step();
    chk("sq_cap_req", 32'(instr_req_o), 32'd0);
    chk("sq_pend", 32'(pend.size()), 32'd2);
    budget = -1;
    do_redirect(32'h200);
    step();
    chk("sq_addr", instr_addr_o, 32'h200);
    chk("sq_req", 32'(instr_req_o), 32'd1);
    expect_i(32'h200, mem_rd(32'h200), 1'b0, 1'b0, 1'b1);
    expect_i(32'h204, mem_rd(32'h204), 1'b0, 1'b0, 1'b1);
    drain("squash");

    // backpressure fills exactly DEPTH words
    quiesce();
    do_redirect(32'h400);
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) begin
        snap_pc    = out_pc_o;
        snap_instr = out_instr_o;
      end
    end
    chk("bp_grants", 32'(grants), 32'(DEPTH));
    chk("bp_req", 32'(instr_req_o), 32'd0);
    chk("bp_addr", instr_addr_o, 32'h40C);
    chk("bp_valid", 32'(out_valid_o), 32'd1);
    chk("bp_pc_hold", out_pc_o, snap_pc);
    chk("bp_instr_hold", out_instr_o, snap_instr);
    chk("bp_pc", out_pc_o, 32'h400);
    for (int i = 0; i < 4; i++) begin
      expect_i(32'h400 + 32'(4 * i), mem_rd(32'h400 + 32'(4 * i)), 1'b0, 1'b0, 1'b1);
    end
    drain("bp");

    // bus error tagging, straddled and direct
    quiesce();
    mem_ovr[32'h0C] = 32'h0003_0001;
    err_map[32'h10] = 1'b1;
    do_redirect(32'h0E);
    expect_i(32'h0E, '0, 1'b0, 1'b1, 1'b0);
    drain("err_strad");
    quiesce();
    do_redirect(32'h10);
    expect_i(32'h10, '0, 1'b0, 1'b1, 1'b0);
    drain("err_word");

    // async reset in the middle of traffic
    quiesce();
    do_redirect(32'h500);
    step();
    step();
    rstn           = 1'b0;
    instr_rvalid_i = 1'b0;
    redirect_i     = 1'b0;
    #1;
    chk("mrst_req", 32'(instr_req_o), 32'd0);
    chk("mrst_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_pc", out_pc_o, PC_RST);
    chk("mrst_addr", instr_addr_o, PC_RST);
    pend.delete();
    @(negedge clk);
    rstn = 1'b1;
    expect_i(PC_RST, mem_rd(PC_RST), 1'b0, 1'b0, 1'b1);
    expect_i(PC_RST + 32'd4, mem_rd(PC_RST + 32'd4), 1'b0, 1'b0, 1'b1);
    drain("mrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
